// File: rtl/bcd_pkg.sv
// Shared BCD constants and the digit-legality helper used by the
// N-digit decimal counter and its per-digit cells.
package bcd_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit register: clear, sanitised load, or a single +/-1 step
// that rolls 9->0 going up and 0->9 going down.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  logic [3:0] digit_next;

  // next digit value: clr > load > step > hold
  always_comb begin
    digit_next = digit;
    if (clr) begin
      digit_next = BCD_MIN;
    end else if (load) begin
      digit_next = is_bcd(load_val) ? load_val : BCD_MIN;
    end else if (step) begin
      if (up) begin
        digit_next = (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit_next = (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end else begin
      digit_next = digit;
    end
  end

  // digit register
  always_ff @(posedge clk) begin
    digit <= digit_next;
  end

  assign at_max = (digit == BCD_MAX);
  assign at_min = (digit == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit synchronous BCD event counter with load, wrap/saturate boundary
// handling, carry and overflow flags and a display snapshot register.
module bcd_counter_ndigit
  import bcd_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int WRAP   = 1
) (
  input  logic                  F_IN,
  input  logic                  CLR,
  input  logic                  ENA,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   D_IN,
  input  logic                  LATCH,
  output logic [4*DIGITS-1:0]   Q,
  output logic [4*DIGITS-1:0]   HOLD,
  output logic                  CARRY,
  output logic                  OVF,
  output logic                  BAD_LOAD
);

  localparam logic WRAP_EN = (WRAP != 0);

  logic [DIGITS:0]   chain_max;
  logic [DIGITS:0]   chain_min;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] bad_digit;
  logic              boundary;
  logic              freeze;

  assign chain_max[0] = 1'b1;
  assign chain_min[0] = 1'b1;

  // chain[k] is true when every digit below k sits at the end value,
  // so all digits step on the same edge without rippling through registers
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      assign chain_max[g+1] = chain_max[g] & at_max[g];
      assign chain_min[g+1] = chain_min[g] & at_min[g];
      assign bad_digit[g]   = ~is_bcd(D_IN[4*g +: 4]);
      assign step[g]        = ENA & ~freeze & (UP ? chain_max[g] : chain_min[g]);

      bcd_digit_cell u_cell (
        .clk      (F_IN),
        .clr      (CLR),
        .step     (step[g]),
        .up       (UP),
        .load     (LOAD),
        .load_val (D_IN[4*g +: 4]),
        .digit    (Q[4*g +: 4]),
        .at_max   (at_max[g]),
        .at_min   (at_min[g])
      );
    end
  endgenerate

  // whole count sits at the end value in the current direction
  assign boundary = UP ? chain_max[DIGITS] : chain_min[DIGITS];
  assign freeze   = boundary & ~WRAP_EN;

  // snapshot and status flags
  always_ff @(posedge F_IN) begin
    if (CLR) begin
      HOLD     <= '0;
      CARRY    <= 1'b0;
      OVF      <= 1'b0;
      BAD_LOAD <= 1'b0;
    end else begin
      HOLD     <= LATCH ? Q : HOLD;
      CARRY    <= ~LOAD & ENA & boundary & WRAP_EN;
      BAD_LOAD <= LOAD & (|bad_digit);
      OVF      <= OVF | (~LOAD & ENA & boundary);
    end
  end

endmodule

// File: doc/bcd_counter_ndigit.md
# bcd_counter_ndigit

Parametrised N-digit synchronous BCD (decimal) event counter with enable, up/down direction, parallel decimal load, wrap-or-saturate mode, carry/borrow pulse and a snapshot (hold) register for display. It is the general counting core for the frequency-meter datapath. F_IN is the measured signal used as clock, and the hold register feeds the display multiplexer while counting continues.

## Interface
- DIGITS, default 6: number of BCD digits; legal range 1..8. Q width is 4*DIGITS.
- WRAP, default 1: 1 = modulo-10^DIGITS wrap; 0 = saturate at the end values.

- F_IN  input  1  clock; all state changes on its rising edge.
- CLR  input  1  reset; synchronous, active-high, highest priority.
- ENA  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LOAD  input  1  parallel load of D_IN; overrides counting.
- D_IN  input  4*DIGITS  load value, digit k in bits [4k+3:4k].
- LATCH  input  1  copy the current Q into HOLD.
- Q  output  4*DIGITS  live count, BCD, digit 0 least significant.
- HOLD  output  4*DIGITS  snapshot register.
- CARRY  output  1  one-cycle pulse on a wrap (up) or borrow (down).
- OVF  output  1  sticky; set on any wrap, borrow or saturation hit.
- BAD_LOAD  output  1  one-cycle pulse when a loaded digit was greater than 9.

## Operation
- Priority per edge: CLR > LOAD > (ENA & count) > hold.
- CLR: Q=0, HOLD=0, CARRY=0, OVF=0, BAD_LOAD=0.
- LOAD: each D_IN digit > 9 is replaced by 0 in Q; BAD_LOAD=1 if any digit was replaced. OVF is unchanged and CARRY=0.
- Count up, digit k:
  - Increments if all lower digits equal 9.
  - A digit at 9 that increments goes to 0.
- Count down, digit k:
  - Decrements if all lower digits equal 0.
  - A digit at 0 that decrements goes to 9.
- Boundary, up from all-9s:
  - WRAP=1: Q goes to all-0s, CARRY=1, OVF=1.
  - WRAP=0: Q stays at all-9s, CARRY=0, OVF=1.
- Boundary, down from all-0s:
  - WRAP=1: Q goes to all-9s, CARRY=1, OVF=1.
  - WRAP=0: Q stays at 0, CARRY=0, OVF=1.
- ENA=0, or no LOAD/CLR: Q holds, CARRY=0, BAD_LOAD=0.
- LATCH:
  - Captures the value Q had before this edge.
  - It is independent of LOAD and ENA, so LATCH and a count on the same edge give HOLD = old Q.
  - CLR on the same edge gives HOLD=0.
- Q never holds a non-BCD digit, in any sequence.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Count latency is 1 edge: Q reflects a count/load/clear on the edge where it is sampled.
- CARRY and BAD_LOAD are high for exactly one F_IN cycle, aligned with the Q update that caused them.
- OVF rises on the same edge as the triggering update and stays high until CLR.
- Direction may change on any edge with no dead cycle.
- Mid-operation CLR takes effect on that edge regardless of other inputs.

## Structure
- Shared package bcd_pkg holds:
  - BCD_MAX = 4'd9, BCD_MIN = 4'd0, digit width 4.
  - A function returning 1 if a nibble is a legal BCD digit.
- Sub-module bcd_digit_cell: one 4-bit digit register.
  - Inputs: step-enable, up, load, load value, clr.
  - Outputs: digit, at_max (==9), at_min (==0).
  - Generated DIGITS times.
- The top module builds the ripple-free enable chain as an AND of the lower digits' at_max/at_min, and adds the HOLD, CARRY, OVF and BAD_LOAD registers.

## Test plan
- DIGITS=6, WRAP=1. CLR, then ENA=1, UP=1 for 1,000,000 edges -> Q counts 000000..999999 then 000000. CARRY is a single pulse at the wrap edge and OVF=1.
- Load 000000, UP=0, one edge -> Q=999999, CARRY=1. Next edge -> Q=999998, CARRY=0.
- WRAP=0: load 999998, UP=1, 3 edges -> Q=999999 and stays, CARRY never asserts, OVF=1 from the 2nd edge. CLR -> all outputs 0.
- Load D_IN=0x12A4F7 -> Q=0x120407, BAD_LOAD pulses for 1 cycle, OVF unchanged.
- Q=000129, ENA=1, UP=1, LATCH=1 on the same edge -> HOLD=000129, Q=000130. CLR together with LOAD and LATCH -> Q=0, HOLD=0.
- DIGITS=1 and DIGITS=8 builds: exercise the up-wrap, down-borrow and load cases; check every Q nibble is ≤9 on every cycle under random ENA/UP/LOAD/LATCH.
